// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store access unit.
//   - RV funct3 codes for loads and stores
//   - FSM state encoding
//   - access length constants (bytes) plus length/mask helpers
package lsu_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  localparam logic [2:0] LEN_B = 3'd1;
  localparam logic [2:0] LEN_H = 3'd2;
  localparam logic [2:0] LEN_W = 3'd4;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  // Access length in bytes from funct3[1:0]; 0 marks the unused encoding.
  function automatic logic [2:0] len_of(input logic [2:0] func);
    case (func[1:0])
      2'b00:   return LEN_B;
      2'b01:   return LEN_H;
      2'b10:   return LEN_W;
      default: return 3'd0;
    endcase
  endfunction

  // Byte-lane mask for right-justified data of the given length.
  function automatic logic [31:0] len_mask(input logic [2:0] len);
    case (len)
      LEN_B:   return 32'h0000_00ff;
      LEN_H:   return 32'h0000_ffff;
      LEN_W:   return 32'hffff_ffff;
      default: return 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// lsu_load_ext: sign/zero extension of right-justified SRAM read data.
//   func     : RV load funct3 (LB/LH/LW/LBU/LHU)
//   rdata    : raw right-justified read data
//   ext_data : extended result; LW and any other code pass rdata through
module lsu_load_ext
  import lsu_pkg::*;
(
  input  logic [2:0]  func,
  input  logic [31:0] rdata,
  output logic [31:0] ext_data
);

  // NOTE: a combinational block assigns every output first so no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    ext_data = rdata;
    case (func)
      LB:      ext_data = {{24{rdata[7]}}, rdata[7:0]};
      LH:      ext_data = {{16{rdata[15]}}, rdata[15:0]};
      LBU:     ext_data = {24'h0, rdata[7:0]};
      LHU:     ext_data = {16'h0, rdata[15:0]};
      default: ext_data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_access.sv
// lsu_mem_access: load/store access unit in front of the data SRAM.
// Accepts one request over req_valid/req_ready, checks alignment and funct3,
// issues a one-cycle SRAM strobe, waits LAT cycles for read data and returns
// the extended result (or a store acknowledge / error) over resp_valid/ready.
//   clk, rst        : clock, synchronous active-high reset
//   req_*           : request channel (wen, funct3, byte address, store data)
//   resp_*          : response channel (extended load data, error flag)
//   mem_*           : SRAM strobes, address, write data, length, read data
// Parameter LAT (1..15): SRAM read latency in cycles.
// Optional macro LSU_MTRACE_EN: prints one trace line per response handshake
// in simulation.
module lsu_mem_access
  import lsu_pkg::*;
#(
  parameter int unsigned LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [2:0]  req_func,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_ren,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_len,
  input  logic [31:0] mem_rdata
);

  state_t      state, state_nx;
  logic        wen_q;
  logic [2:0]  func_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  len_q;
  logic [3:0]  cnt_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        accept;
  logic [2:0]  req_len;
  logic        req_misaligned;
  logic        req_illegal;
  logic        req_err;
  logic [31:0] ext_data;

  assign req_ready = (state == IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  assign req_len        = len_of(req_func);
  assign req_misaligned = ((req_len == LEN_H) && req_addr[0]) ||
                          ((req_len == LEN_W) && (req_addr[1:0] != 2'b00));
  assign req_illegal    = req_wen ? !(req_func inside {SB, SH, SW})
                                  : !(req_func inside {LB, LH, LW, LBU, LHU});
  assign req_err        = req_misaligned || req_illegal;

  lsu_load_ext u_load_ext (
    .func     (func_q),
    .rdata    (mem_rdata),
    .ext_data (ext_data)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      wen_q   <= 1'b0;
      func_q  <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      len_q   <= 3'd0;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        wen_q   <= req_wen;
        func_q  <= req_func;
        addr_q  <= req_addr;
        wdata_q <= req_wdata & len_mask(req_len);
        len_q   <= req_len;
        rdata_q <= 32'd0;
        err_q   <= req_err;
      end
      if (state == ISSUE) begin
        cnt_q <= 4'(LAT);
      end else if (state == WAIT) begin
        cnt_q <= cnt_q - 4'd1;
        // Last wait cycle: read data is valid now. Stores report zero.
        if (cnt_q == 4'd1) begin
          rdata_q <= wen_q ? 32'd0 : ext_data;
        end
      end
    end
  end

  always_comb begin
    state_nx   = state;
    resp_valid = 1'b0;
    mem_ren    = 1'b0;
    mem_wen    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nx = req_err ? RESP : ISSUE;
      end
      ISSUE: begin
        // Gated by rst so a store coinciding with reset never commits.
        mem_ren  = !wen_q && !rst;
        mem_wen  = wen_q && !rst;
        state_nx = WAIT;
      end
      WAIT: begin
        if (cnt_q == 4'd1) state_nx = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_len    = len_q;

`ifdef LSU_MTRACE_EN
  always_ff @(posedge clk) begin
    if (!rst && resp_valid && resp_ready) begin
      $display("mtrace %s addr=%08x len=%0d data=%08x err=%0d",
               wen_q ? "W" : "R", addr_q, len_q,
               wen_q ? wdata_q : rdata_q, err_q);
    end
  end
`endif

endmodule
